// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared definitions for the time-multiplexed "1101" detector scheduler.
//   det_state_t : 3-bit Moore detector state (encodings ST_A..ST_E)
//   det_step()  : one detector step, returns the next state for (state, bit)
// Used by seq_det_sched. Optional build macro used by the top: SEQ_DET_CNT_EN.
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_A = 3'b000,  // nothing useful seen
        ST_B = 3'b010,  // seen "1"
        ST_C = 3'b110,  // seen "11"
        ST_D = 3'b100,  // seen "110"
        ST_E = 3'b011   // seen "1101" (match state)
    } det_state_t;

    // Next state of the overlapping "1101" detector. Any encoding outside
    // the five legal states falls back to ST_A.
    function automatic det_state_t det_step(input det_state_t st, input logic b);
        det_state_t nxt;
        case (st)
            ST_A:    nxt = b ? ST_B : ST_A;
            ST_B:    nxt = b ? ST_C : ST_A;
            ST_C:    nxt = b ? ST_C : ST_D;
            ST_D:    nxt = b ? ST_E : ST_A;
            ST_E:    nxt = b ? ST_C : ST_A;
            default: nxt = ST_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// seq_det_rr_arb
// Purely combinational round-robin arbiter. The search starts one past ptr
// and wraps modulo NUM_CH; the first requesting channel wins.
// Ports:
//   req       in  NUM_CH  request vector
//   ptr       in  CH_W    last granted channel
//   gnt       out NUM_CH  one-hot grant (all zero when no request)
//   gnt_idx   out CH_W    index of the granted channel (0 when none)
//   gnt_valid out 1       a grant was issued
module seq_det_rr_arb #(
    parameter int  NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_valid
);

    always_comb begin
        int c;
        c         = 0;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // Offset NUM_CH brings the search back to ptr itself, so the last
        // granted channel is considered only after every other channel.
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (int'(ptr) + k) % NUM_CH;
            if (!gnt_valid && req[c]) begin
                gnt_valid = 1'b1;
                gnt[c]    = 1'b1;
                gnt_idx   = CH_W'(c);
            end
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched
// Shares one "1101" Moore detector step between NUM_CH serial channels.
// Each channel owns a 1-deep bit buffer and a saved detector state; a
// round-robin arbiter services one pending channel per cycle.
// Optional build macro: SEQ_DET_CNT_EN enables per-channel saturating match
// counters and the rd_ch/rd_cnt read port (otherwise rd_cnt reads 0).
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              scheduler enable (low freezes service, accepts continue)
//   clr             synchronous clear of all channel state and counters
//   ch_valid/ch_bit per-channel input bit and its valid
//   ch_ready        per-channel buffer empty
//   det_valid/det_ch one-cycle detection pulse and matching channel
//   rd_ch/rd_cnt    combinational counter read
// Handshake: channel i transfers a bit on any edge where ch_valid[i] and
// ch_ready[i] are both high; ch_ready[i] drops the cycle after and only
// rises again once the buffered bit has been serviced.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_bit,
    output logic [NUM_CH-1:0] ch_ready,
    output logic              det_valid,
    output logic [CH_W-1:0]   det_ch,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_cnt
);

    det_state_t        state_q [NUM_CH];
    det_state_t        state_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] bit_q, bit_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              det_valid_q, det_valid_d;
    logic [CH_W-1:0]   det_ch_q, det_ch_d;

    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_valid;
    det_state_t        svc_next;
    logic              svc_match;

    assign arb_req = en ? pend_q : '0;

    seq_det_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // The single shared detector step, applied to the granted channel.
    assign svc_next  = det_step(state_q[gnt_idx], bit_q[gnt_idx]);
    assign svc_match = gnt_valid && (svc_next == ST_E);

    assign ch_ready  = ~pend_q;
    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        bit_d       = bit_q;
        rr_ptr_d    = rr_ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        if (clr) begin
            // Clear wins over both accept and service; rr_ptr is kept.
            for (int i = 0; i < NUM_CH; i++) begin
                state_d[i] = ST_A;
            end
            pend_d = '0;
        end else begin
            // Accept only into empty buffers. The granted channel is always
            // pending, so its accept and its service never collide.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i] && !pend_q[i]) begin
                    pend_d[i] = 1'b1;
                    bit_d[i]  = ch_bit[i];
                end
            end
            if (gnt_valid) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (gnt[i]) begin
                        state_d[i] = svc_next;
                        pend_d[i]  = 1'b0;
                    end
                end
                rr_ptr_d    = gnt_idx;
                det_valid_d = svc_match;
                if (svc_match) begin
                    det_ch_d = gnt_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_A;
            end
            pend_q      <= '0;
            bit_q       <= '0;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            bit_q       <= bit_d;
            rr_ptr_q    <= rr_ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
        end
    end

`ifdef SEQ_DET_CNT_EN
    // Array is sized to the full index range so rd_ch can never select past
    // the end; entries at or above NUM_CH are never written and read as 0.
    localparam int CNT_N = 2 ** CH_W;

    logic [CNT_W-1:0] cnt_q [CNT_N];
    logic [CNT_W-1:0] cnt_d [CNT_N];

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            for (int i = 0; i < CNT_N; i++) begin
                cnt_d[i] = '0;
            end
        end else if (svc_match && (cnt_q[gnt_idx] != {CNT_W{1'b1}})) begin
            cnt_d[gnt_idx] = cnt_q[gnt_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CNT_N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_cnt = cnt_q[rd_ch];
`else
    logic unused_rd_ch;
    assign unused_rd_ch = ^rd_ch;
    assign rd_cnt       = '0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched
// Directed and randomized stimulus for seq_det_sched, checked every cycle
// against a reference model that tracks each channel's last four serviced
// bits (a match is those bits reading 1101) and a round-robin search over
// pending buffers. Expected counter values follow SEQ_DET_CNT_EN.
module tb_seq_det_sched;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 2;
    localparam int CH_W   = $clog2(NUM_CH);

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              clr;
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_bit;
    logic [NUM_CH-1:0] ch_ready;
    logic              det_valid;
    logic [CH_W-1:0]   det_ch;
    logic [CH_W-1:0]   rd_ch;
    logic [CNT_W-1:0]  rd_cnt;

    seq_det_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .ch_valid  (ch_valid),
        .ch_bit    (ch_bit),
        .ch_ready  (ch_ready),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .rd_ch     (rd_ch),
        .rd_cnt    (rd_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m_pend [NUM_CH];
    bit m_bit  [NUM_CH];
    int m_hist [NUM_CH];
    int m_cnt  [NUM_CH];
    int m_ptr;
    bit m_dv;
    int m_dch;

    int tests    = 0;
    int fails    = 0;
    int det_seen = 0;
    int low_run  [NUM_CH];
    int max_run  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_cnt(input int ch);
`ifdef SEQ_DET_CNT_EN
        return m_cnt[ch];
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_pend[i] = 1'b0;
            m_bit[i]  = 1'b0;
            m_hist[i] = 0;
            m_cnt[i]  = 0;
        end
        m_ptr = NUM_CH - 1;
        m_dv  = 1'b0;
        m_dch = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit acc [NUM_CH];
        int g;
        if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_hist[i] = 0;
                m_pend[i] = 1'b0;
                m_cnt[i]  = 0;
            end
            m_dv = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) acc[i] = ch_valid[i] && !m_pend[i];
            g = -1;
            if (en) begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    if (g < 0 && m_pend[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
                end
            end
            m_dv = 1'b0;
            if (g >= 0) begin
                m_hist[g] = ((m_hist[g] << 1) | int'(m_bit[g])) & 15;
                m_pend[g] = 1'b0;
                m_ptr     = g;
                if (m_hist[g] == 13) begin
                    m_dv  = 1'b1;
                    m_dch = g;
                    if (m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g]++;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc[i]) begin
                    m_pend[i] = 1'b1;
                    m_bit[i]  = ch_bit[i];
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] exp_ready;
        for (int i = 0; i < NUM_CH; i++) exp_ready[i] = !m_pend[i];
        chk("ch_ready", 32'(ch_ready), 32'(exp_ready));
        chk("det_valid", 32'(det_valid), 32'(m_dv));
        if (m_dv) chk("det_ch", 32'(det_ch), 32'(m_dch));
        chk("rd_cnt", 32'(rd_cnt), 32'(exp_cnt(int'(rd_ch))));
        if (det_valid === 1'b1) det_seen++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_ready[i] === 1'b0) low_run[i]++;
            else low_run[i] = 0;
            if (low_run[i] > max_run) max_run = low_run[i];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // One bit on one channel followed by a gap cycle.
    task automatic feed(input int ch, input logic b);
        ch_valid     = '0;
        ch_valid[ch] = 1'b1;
        ch_bit[ch]   = b;
        tick();
        ch_valid = '0;
        tick();
    endtask

    task automatic feed_seq(input int ch, input int n, input logic [15:0] bits);
        for (int i = n - 1; i >= 0; i--) feed(ch, bits[i]);
    endtask

    task automatic idle(input int n);
        ch_valid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [7:0] pat2;
        int         idx2;

        rst      = 1'b1;
        en       = 1'b1;
        clr      = 1'b0;
        ch_valid = '0;
        ch_bit   = '0;
        rd_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) low_run[i] = 0;
        model_reset();

        // Reset values
        #12;
        chk("rst_det_valid", 32'(det_valid), 32'd0);
        chk("rst_det_ch", 32'(det_ch), 32'd0);
        chk("rst_ready", 32'(ch_ready), 32'hF);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ch0: 1101 -> one detection on channel 0
        det_seen = 0;
        feed_seq(0, 4, 16'b1101);
        idle(2);
        chk("ch0_dets", 32'(det_seen), 32'd1);
        rd_ch = 2'd0;
        #1;
        chk("ch0_cnt", 32'(rd_cnt), `ifdef SEQ_DET_CNT_EN 32'd1 `else 32'd0 `endif);

        // ch1: 1101101 -> two overlapping detections, then 11001 -> none
        det_seen = 0;
        feed_seq(1, 7, 16'b1101101);
        idle(2);
        chk("ch1_overlap_dets", 32'(det_seen), 32'd2);
        rd_ch = 2'd1;
        #1;
        chk("ch1_cnt", 32'(rd_cnt), `ifdef SEQ_DET_CNT_EN 32'd2 `else 32'd0 `endif);
        det_seen = 0;
        feed_seq(1, 5, 16'b11001);
        idle(2);
        chk("ch1_no_det", 32'(det_seen), 32'd0);

        // All channels valid every cycle; only ch2 carries 11011101
        det_seen = 0;
        max_run  = 0;
        pat2     = 8'b11011101;
        idx2     = 0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            ch_valid    = 4'b1011;
            ch_bit      = '0;
            ch_valid[2] = 1'b0;
            if (idx2 < 8 && !m_pend[2]) begin
                ch_valid[2] = 1'b1;
                ch_bit[2]   = pat2[7 - idx2];
                idx2++;
            end
            tick();
        end
        chk("rr_max_wait_ok", 32'(max_run <= NUM_CH), 32'd1);
        idle(6);
        chk("ch2_dets", 32'(det_seen), 32'd2);

        // Clear, then 5 matches on ch3 saturate a 2-bit counter at 3
        clr = 1'b1;
        tick();
        clr = 1'b0;
        det_seen = 0;
        for (int r = 0; r < 5; r++) feed_seq(3, 4, 16'b1101);
        idle(2);
        chk("ch3_dets", 32'(det_seen), 32'd5);
        rd_ch = 2'd3;
        #1;
        chk("ch3_sat", 32'(rd_cnt), `ifdef SEQ_DET_CNT_EN 32'd3 `else 32'd0 `endif);
        rd_ch = 2'd0;
        #1;
        chk("ch0_after_clr", 32'(rd_cnt), 32'd0);

        // Async reset mid-stream with a bit still pending on ch0
        feed_seq(0, 3, 16'b110);
        ch_valid = 4'b0001;
        ch_bit   = 4'b0001;
        tick();
        ch_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(ch_ready), 32'hF);
        chk("arst_det_valid", 32'(det_valid), 32'd0);
        chk("arst_rd_cnt", 32'(rd_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        det_seen = 0;
        feed(0, 1'b1);
        idle(2);
        chk("arst_single1", 32'(det_seen), 32'd0);
        feed_seq(0, 4, 16'b1101);
        idle(2);
        chk("arst_full", 32'(det_seen), 32'd1);

        // clr together with an accept on ch0 drops the bit
        ch_valid = 4'b0001;
        ch_bit   = 4'b0001;
        clr      = 1'b1;
        tick();
        clr      = 1'b0;
        ch_valid = '0;
        chk("clr_drop_ready0", 32'(ch_ready[0]), 32'd1);
        chk("clr_cnt0", 32'(rd_cnt), 32'd0);

        // en low holds a pending bit; service resumes with en high
        en       = 1'b0;
        ch_valid = 4'b0001;
        ch_bit   = 4'b0001;
        tick();
        ch_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("en0_hold_ready0", 32'(ch_ready[0]), 32'd0);
        en = 1'b1;
        tick();
        chk("en1_resume_ready0", 32'(ch_ready[0]), 32'd1);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            en       = ($urandom_range(0, 9) != 0);
            clr      = ($urandom_range(0, 79) == 0);
            ch_valid = NUM_CH'($urandom);
            ch_bit   = NUM_CH'($urandom);
            rd_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            tick();
        end
        clr = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
